// File: rtl/patt_gen_scroll_pkg.sv
// patt_gen_scroll_pkg: colour constants and pattern mode encodings shared by the pattern generator
package patt_gen_scroll_pkg;
  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] GREEN = 3'b010;
  localparam logic [2:0] BLUE  = 3'b001;
  localparam logic [2:0] CYAN  = 3'b011;
  typedef enum logic [1:0] {
    MODE_STATIC_BARS = 2'd0,
    MODE_BAND        = 2'd1,
    MODE_CHECKER     = 2'd2,
    MODE_SCROLL_BARS = 2'd3
  } mode_e;
endpackage

// File: rtl/patt_gen_scroll_if.sv
// patt_gen_scroll_if: pixel coordinate/mode in, colour/frame pulse out
//   row_i/column_i/en_i/mode_i : from the VGA timing block (master drives)
//   rgb_o/frame_o              : registered pattern output (slave drives)
interface patt_gen_scroll_if #(
  parameter int ROW_W = 9,
  parameter int COL_W = 10
);
  logic [ROW_W-1:0] row_i;
  logic [COL_W-1:0] column_i;
  logic             en_i;
  logic [1:0]       mode_i;
  logic [2:0]       rgb_o;
  logic             frame_o;
  modport master (output row_i, column_i, en_i, mode_i, input rgb_o, frame_o);
  modport slave  (input row_i, column_i, en_i, mode_i, output rgb_o, frame_o);
endinterface

// File: rtl/patt_gen_scroll_scroll_ctr.sv
// patt_gen_scroll_scroll_ctr: counter stepping 0..MAX-1 and wrapping, one step per step_i
//   clk_i, rst_i (sync, active high), step_i in; value_o out
module patt_gen_scroll_scroll_ctr #(
  parameter int MAX   = 480,
  parameter int WIDTH = 9
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             step_i,
  output logic [WIDTH-1:0] value_o
);
  localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX - 1);
  logic [WIDTH-1:0] value_q, value_d;
  always_comb value_d = !step_i ? value_q : (value_q == LAST) ? '0 : value_q + 1'b1;
  always_ff @(posedge clk_i) value_q <= rst_i ? '0 : value_d;
  assign value_o = value_q;
endmodule

// File: rtl/patt_gen_scroll.sv
// patt_gen_scroll: registered 4-mode VGA test pattern generator with scrolling band/bars
//   clk_i pixel clock, rst_i sync active-high reset
//   bus.slave: row_i/column_i/en_i/mode_i in, rgb_o/frame_o out (1-cycle latency)
module patt_gen_scroll
  import patt_gen_scroll_pkg::*;
#(
  parameter int ROW_W      = 9,
  parameter int COL_W      = 10,
  parameter int V_ACTIVE   = 480,
  parameter int H_ACTIVE   = 640,
  parameter int BAND_H     = 160,
  parameter int BAR_LOG2   = 6,
  parameter int CHK_LOG2   = 5,
  parameter int SCROLL_DIV = 1
) (
  input logic              clk_i,
  input logic              rst_i,
  patt_gen_scroll_if.slave bus
);
  localparam int DW = $clog2(SCROLL_DIV + 1);
  localparam logic [DW-1:0]  DIV_LAST = DW'(SCROLL_DIV - 1);
  localparam logic [ROW_W:0] V_X      = (ROW_W + 1)'(V_ACTIVE);
  localparam logic [ROW_W:0] B_X      = (ROW_W + 1)'(BAND_H);
  localparam logic [COL_W:0] H_X      = (COL_W + 1)'(H_ACTIVE);
  mode_e            mode_q, mode_d;
  logic [DW-1:0]    div_q, div_d;
  logic [2:0]       rgb_q, rgb_d, pix;
  logic             frame_q, frame_d, frame_start, step;
  logic [ROW_W-1:0] band_top;
  logic [COL_W-1:0] bar_off;
  logic [ROW_W:0]   row_x, top_x, band_d;
  logic [COL_W:0]   col_sum, col_w;
  patt_gen_scroll_scroll_ctr #(.MAX(V_ACTIVE), .WIDTH(ROW_W)) u_band (
    .clk_i(clk_i), .rst_i(rst_i), .step_i(step), .value_o(band_top)
  );
  patt_gen_scroll_scroll_ctr #(.MAX(H_ACTIVE), .WIDTH(COL_W)) u_bar (
    .clk_i(clk_i), .rst_i(rst_i), .step_i(step), .value_o(bar_off)
  );
  always_comb begin
    frame_start = bus.en_i && bus.row_i == '0 && bus.column_i == '0;
    // the frame_start pixel already uses the new mode but the pre-step offsets
    mode_d  = frame_start ? mode_e'(bus.mode_i) : mode_q;
    step    = frame_start && div_q == DIV_LAST;
    div_d   = !frame_start ? div_q : step ? '0 : div_q + 1'b1;
    row_x   = {1'b0, bus.row_i};
    top_x   = {1'b0, band_top};
    band_d  = row_x >= top_x ? row_x - top_x : row_x + V_X - top_x;
    col_sum = {1'b0, bus.column_i} + {1'b0, bar_off};
    col_w   = col_sum >= H_X ? col_sum - H_X : col_sum;
    pix     = mode_d == MODE_STATIC_BARS ? 3'(bus.column_i >> BAR_LOG2) :
              mode_d == MODE_BAND        ? (band_d < B_X ? BLUE : CYAN) :
              mode_d == MODE_CHECKER     ? ((bus.column_i[CHK_LOG2] ^ bus.row_i[CHK_LOG2]) ? RED : GREEN) :
                                           3'(col_w >> BAR_LOG2);
    rgb_d   = bus.en_i ? pix : BLACK;
    frame_d = frame_start;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q  <= MODE_STATIC_BARS;
      div_q   <= '0;
      rgb_q   <= BLACK;
      frame_q <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      div_q   <= div_d;
      rgb_q   <= rgb_d;
      frame_q <= frame_d;
    end
  end
  assign bus.rgb_o   = rgb_q;
  assign bus.frame_o = frame_q;
endmodule

// File: tb/tb_patt_gen_scroll.sv
// tb_patt_gen_scroll: two generators (scroll every frame / every 2 frames) checked against a frame-count model
module tb_patt_gen_scroll;
  localparam int V = 480, H = 640, BAND = 160;
  logic clk = 1'b0, rst = 1'b1;
  int checks = 0, errors = 0;
  int k = 0, m = 0;
  logic [2:0] pend0 = '0, pend1 = '0, cur0 = '0, cur1 = '0;
  logic pend_f = 1'b0, cur_f = 1'b0, pend_rv = 1'b0, cur_rv = 1'b0, pend_on = 1'b0, cur_on = 1'b0;
  always #5 clk = ~clk;
  patt_gen_scroll_if #(.ROW_W(9), .COL_W(10)) if0 ();
  patt_gen_scroll_if #(.ROW_W(9), .COL_W(10)) if1 ();
  patt_gen_scroll #(.SCROLL_DIV(1)) dut0 (.clk_i(clk), .rst_i(rst), .bus(if0.slave));
  patt_gen_scroll #(.SCROLL_DIV(2)) dut1 (.clk_i(clk), .rst_i(rst), .bus(if1.slave));
  // colour from the pattern rules, given the number of scroll steps taken so far
  function automatic logic [2:0] colour(int md, int r, int c, int s);
    int bt = s % V;
    int bo = s % H;
    case (md)
      0: return 3'((c / 64) % 8);
      1: return (((r - bt + V) % V) < BAND) ? 3'b001 : 3'b011;
      2: return (((c / 32) + (r / 32)) % 2 == 1) ? 3'b100 : 3'b010;
      default: return 3'((((c + bo) % H) / 64) % 8);
    endcase
  endfunction
  task automatic chk(input string nm, input logic [2:0] got, input logic [2:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %b want %b at %0t", nm, got, want, $time);
    end
  endtask
  // one clock per call: commits the previous expectation, drives new inputs, predicts their result
  task automatic px(input logic r, input logic e, input int row, input int col, input int md);
    logic fs;
    @(posedge clk);
    cur0 = pend0; cur1 = pend1; cur_f = pend_f; cur_rv = pend_rv; cur_on = pend_on;
    #1;
    rst = r;
    if0.en_i = e; if0.row_i = 9'(row); if0.column_i = 10'(col); if0.mode_i = 2'(md);
    if1.en_i = e; if1.row_i = 9'(row); if1.column_i = 10'(col); if1.mode_i = 2'(md);
    pend_on = 1'b1;
    if (r) begin
      k = 0; m = 0; pend0 = '0; pend1 = '0; pend_f = 1'b0; pend_rv = 1'b1;
    end else begin
      fs = e && row == 0 && col == 0;
      if (fs) m = md;
      pend_f  = fs;
      pend_rv = !e || (row < V && col < H);
      pend0   = e ? colour(m, row, col, k) : 3'b000;
      pend1   = e ? colour(m, row, col, k / 2) : 3'b000;
      if (fs) k++;
    end
  endtask
  task automatic probe(input int row, input int col, input int md);
    px(1'b0, 1'b1, row, col, md);
    px(1'b0, 1'b0, 0, 0, md);
    @(negedge clk);
  endtask
  always @(negedge clk) begin
    if (cur_on) begin
      chk("frame0", {2'b00, if0.frame_o}, {2'b00, cur_f});
      chk("frame1", {2'b00, if1.frame_o}, {2'b00, cur_f});
      if (cur_rv) begin
        chk("rgb0", if0.rgb_o, cur0);
        chk("rgb1", if1.rgb_o, cur1);
      end
    end
  end
  initial begin
    if0.en_i = 1'b1; if0.row_i = '0; if0.column_i = '0; if0.mode_i = 2'd2;
    if1.en_i = 1'b1; if1.row_i = '0; if1.column_i = '0; if1.mode_i = 2'd2;
    px(1'b1, 1'b1, 0, 0, 2);
    px(1'b1, 1'b1, 0, 0, 2);
    px(1'b0, 1'b1, 0, 0, 0);
    @(negedge clk);
    chk("rst_rgb", if0.rgb_o, 3'b000);
    chk("rst_frame", {2'b00, if0.frame_o}, 3'b000);
    px(1'b0, 1'b0, 0, 0, 0);
    @(negedge clk);
    chk("first_frame", {2'b00, if0.frame_o}, 3'b001);
    probe(10, 64, 3);  chk("bars_64", if0.rgb_o, 3'b001);
    probe(10, 128, 3); chk("bars_128", if0.rgb_o, 3'b010);
    probe(10, 448, 3); chk("bars_448", if0.rgb_o, 3'b111);
    px(1'b0, 1'b1, 0, 0, 1);
    probe(161, 0, 1); chk("band_161", if0.rgb_o, 3'b001);
    probe(162, 0, 1); chk("band_162", if0.rgb_o, 3'b011);
    probe(1, 0, 1);   chk("band_row1", if0.rgb_o, 3'b011);
    for (int i = 0; i < 400; i++) px(1'b0, 1'b1, 0, 0, 1);
    probe(10, 0, 1);  chk("band_wrap0", if0.rgb_o, 3'b001); chk("band_wrap1", if1.rgb_o, 3'b011);
    probe(401, 0, 1); chk("band_401", if0.rgb_o, 3'b011);
    px(1'b0, 1'b1, 0, 0, 2);
    px(1'b0, 1'b0, 0, 0, 2);
    @(negedge clk);
    chk("chk_origin", if0.rgb_o, 3'b010);
    probe(0, 32, 2);    chk("chk_32_0", if0.rgb_o, 3'b100);
    probe(32, 32, 2);   chk("chk_32_32", if0.rgb_o, 3'b010);
    probe(200, 32, 0);  chk("mode_held", if0.rgb_o, 3'b100);
    px(1'b0, 1'b1, 0, 0, 0);
    probe(200, 64, 2);  chk("mode_switched", if0.rgb_o, 3'b001);
    probe(500, 700, 0);
    px(1'b1, 1'b0, 0, 0, 0);
    px(1'b0, 1'b0, 0, 0, 0);
    @(negedge clk);
    chk("mid_rst", if1.rgb_o, 3'b000);
    px(1'b0, 1'b1, 0, 0, 3);
    probe(5, 0, 3);     chk("sb_start1", if1.rgb_o, 3'b000);
    px(1'b0, 1'b1, 0, 0, 3);
    for (int i = 0; i < 254; i++) px(1'b0, 1'b1, 0, 0, 3);
    probe(5, 0, 3);     chk("sb_div2", if1.rgb_o, 3'b010); chk("sb_div1", if0.rgb_o, 3'b100);
    probe(5, 600, 3);   chk("sb_wrap1", if1.rgb_o, 3'b001); chk("sb_wrap0", if0.rgb_o, 3'b011);
    px(1'b0, 1'b0, 5, 64, 3);
    px(1'b0, 1'b0, 5, 64, 3);
    @(negedge clk);
    chk("en_off", if1.rgb_o, 3'b000);
    px(1'b0, 1'b0, 0, 0, 0);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
